// File: rtl/inv_lut_2_2_if.sv
// Video bus for the inverse gamma LUT: 12-bit encoded RGB plus sync in, 8-bit linear RGB plus sync out.
// The video source holds the master modport and the LUT holds the slave modport.
interface inv_lut_2_2_if;
    logic        I_en;
    logic        I_vs;
    logic        I_hs;
    logic        I_de;
    logic [11:0] I_r;
    logic [11:0] I_g;
    logic [11:0] I_b;
    logic        O_vs;
    logic        O_hs;
    logic        O_de;
    logic [7:0]  O_r;
    logic [7:0]  O_g;
    logic [7:0]  O_b;

    modport master (
        output I_en, I_vs, I_hs, I_de, I_r, I_g, I_b,
        input  O_vs, O_hs, O_de, O_r, O_g, O_b
    );

    modport slave (
        input  I_en, I_vs, I_hs, I_de, I_r, I_g, I_b,
        output O_vs, O_hs, O_de, O_r, O_g, O_b
    );
endinterface

// File: rtl/inv_lut_2_2.sv
// Inverse gamma-2.2: 12-bit encoded RGB -> 8-bit linear RGB by an 8-stage binary search over the encode table.
// Latency is 8 clocks for data and sync alike; 1 pixel/clock, no backpressure and no stall.
module inv_lut_2_2 #(
    parameter logic EN_DEFAULT = 1'b1,
    parameter logic VS_POL     = 1'b1
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    inv_lut_2_2_if.slave bus
);

    // T(i) is the largest t with (t/4096)^(11/5) <= (2i+1)/512, i.e. t^11 <= (2i+1)^5 * 2^87,
    // which gives the exact floor without any real arithmetic.
    function automatic logic [3071:0] build_tbl();
        logic [3071:0] tbl;
        logic [159:0]  lim;
        logic [159:0]  base;
        logic [159:0]  p;
        logic [11:0]   r;
        logic [11:0]   c;
        tbl = '0;
        for (int i = 0; i < 256; i++) begin
            base = 160'(2 * i + 1);
            lim  = base;
            for (int k = 0; k < 4; k++) lim = lim * base;
            lim = lim << 87;
            r = '0;
            for (int b = 11; b >= 0; b--) begin
                c = r | (12'd1 << b);
                p = 160'(c);
                for (int k = 0; k < 10; k++) p = p * 160'(c);
                if (p <= lim) r = c;
            end
            tbl[i*12 +: 12] = r;
        end
        return tbl;
    endfunction

    localparam logic [3071:0] TBL = build_tbl();

    typedef struct packed {
        logic             en;
        logic             vs;
        logic             hs;
        logic             de;
        logic [2:0][7:0]  idx;
        logic [2:0][11:0] x;
    } stg_t;

    function automatic logic [7:0] try_bit(input logic [7:0] idx, input logic [11:0] x, input int s);
        logic [7:0] c;
        c = idx | (8'h80 >> s);
        return (TBL[int'(c)*12 +: 12] <= x) ? c : idx;
    endfunction

    logic en_q,      en_d;
    logic vs_prev_q, vs_prev_d;
    stg_t stg_q [8];
    stg_t stg_d [8];
    stg_t src   [8];

    // A frame start latches the request and also applies it to the pixel entering on that clock.
    always_comb begin
        vs_prev_d = bus.I_vs;
        en_d      = en_q;
        if (bus.I_vs == VS_POL && vs_prev_q != VS_POL) en_d = bus.I_en;
    end

    always_comb begin
        src[0].en  = en_d;
        src[0].vs  = bus.I_vs;
        src[0].hs  = bus.I_hs;
        src[0].de  = bus.I_de;
        src[0].idx = '0;
        src[0].x   = {bus.I_b, bus.I_g, bus.I_r};
        for (int s = 1; s < 8; s++) src[s] = stg_q[s-1];
    end

    always_comb begin
        for (int s = 0; s < 8; s++) begin
            stg_d[s] = src[s];
            for (int ch = 0; ch < 3; ch++) begin
                stg_d[s].idx[ch] = try_bit(src[s].idx[ch], src[s].x[ch], s);
                if (s == 7 && !src[s].en) stg_d[s].idx[ch] = src[s].x[ch][11:4];
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            en_q      <= EN_DEFAULT;
            vs_prev_q <= ~VS_POL;
            for (int s = 0; s < 8; s++) stg_q[s] <= '0;
        end else begin
            en_q      <= en_d;
            vs_prev_q <= vs_prev_d;
            for (int s = 0; s < 8; s++) stg_q[s] <= stg_d[s];
        end
    end

    assign bus.O_vs = stg_q[7].vs;
    assign bus.O_hs = stg_q[7].hs;
    assign bus.O_de = stg_q[7].de;
    assign bus.O_r  = stg_q[7].idx[0];
    assign bus.O_g  = stg_q[7].idx[1];
    assign bus.O_b  = stg_q[7].idx[2];

endmodule

// File: tb/tb_inv_lut_2_2.sv
// Directed and swept checks of the inverse gamma LUT against an independent floating-point model.
// Expected outputs ride an 8-deep delay line and are compared on the falling edge.
module tb_inv_lut_2_2;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inv_lut_2_2_if bus();

    inv_lut_2_2 dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic       chk;
        logic       mono;
        logic [2:0] sync;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t       pend [8];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         tm [256];
    logic       mono_on = 1'b0;
    logic [7:0] prev_r  = 8'd0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 256; i++) if (tm[i] <= x) r = i;
        return r;
    endfunction

    task automatic clear_pend();
        for (int s = 0; s < 8; s++) begin
            pend[s].chk  = 1'b0;
            pend[s].mono = 1'b0;
            pend[s].sync = '0;
            pend[s].r    = '0;
            pend[s].g    = '0;
            pend[s].b    = '0;
        end
    endtask

    // Called on a falling edge: check the pixel driven 8 clocks ago, then drive the next one.
    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [11:0] xr, input logic [11:0] xg, input logic [11:0] xb,
                        input logic chk, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        if (pend[7].chk) begin
            check_eq("sync", int'({bus.O_vs, bus.O_hs, bus.O_de}), int'(pend[7].sync));
            check_eq("r", int'(bus.O_r), int'(pend[7].r));
            check_eq("g", int'(bus.O_g), int'(pend[7].g));
            check_eq("b", int'(bus.O_b), int'(pend[7].b));
            if (pend[7].mono) begin
                check_eq("mono", int'(bus.O_r >= prev_r), 1);
                prev_r = bus.O_r;
            end
        end
        for (int s = 7; s > 0; s--) pend[s] = pend[s-1];
        pend[0].chk  = chk;
        pend[0].mono = mono_on;
        pend[0].sync = {vs, hs, de};
        pend[0].r    = er;
        pend[0].g    = eg;
        pend[0].b    = eb;
        bus.I_vs = vs;
        bus.I_hs = hs;
        bus.I_de = de;
        bus.I_r  = xr;
        bus.I_g  = xg;
        bus.I_b  = xb;
        @(negedge clk);
    endtask

    task automatic mstep(input logic vs, input logic hs, input logic de,
                         input logic [11:0] xr, input logic [11:0] xg, input logic [11:0] xb);
        step(vs, hs, de, xr, xg, xb, 1'b1,
             8'(model(int'(xr))), 8'(model(int'(xg))), 8'(model(int'(xb))));
    endtask

    task automatic dstep(input logic [11:0] x, input logic [7:0] e);
        step(1'b0, 1'b1, 1'b1, x, x, x, 1'b1, e, e, e);
    endtask

    task automatic flush();
        repeat (9) step(1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    logic [11:0] rx;

    initial begin
        bus.I_en = 1'b1;
        bus.I_vs = 1'b0;
        bus.I_hs = 1'b0;
        bus.I_de = 1'b0;
        bus.I_r  = '0;
        bus.I_g  = '0;
        bus.I_b  = '0;
        clear_pend();
        for (int i = 0; i < 256; i++)
            tm[i] = int'($floor(4096.0 * $pow((real'(i) + 0.5) / 256.0, 1.0 / 2.2)));

        @(negedge clk);
        check_eq("rst_de", int'(bus.O_de), 0);
        check_eq("rst_r", int'(bus.O_r), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bottom of the curve
        dstep(12'd240, 8'd0);
        dstep(12'd239, 8'd0);
        dstep(12'd0,   8'd0);
        // Anchors and their neighbours
        dstep(12'd396,  8'd1);
        dstep(12'd395,  8'd0);
        dstep(12'd2994, 8'd128);
        dstep(12'd2993, 8'd127);
        dstep(12'd2983, 8'd127);
        dstep(12'd4092, 8'd255);
        dstep(12'd4095, 8'd255);
        flush();

        // Full sweep, back to back, with the other channels decorrelated
        mono_on = 1'b1;
        prev_r  = 8'd0;
        for (int x = 0; x < 4096; x++)
            mstep(1'b0, 1'b1, 1'b1, 12'(x), 12'(4095 - x), 12'(x) ^ 12'h5A5);
        mono_on = 1'b0;
        flush();

        // Enable changes only at frame starts
        bus.I_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 8'd0, 8'd0, 8'd0);
        repeat (3) dstep(12'd2994, 8'd128);
        bus.I_en = 1'b0;
        repeat (3) dstep(12'd2994, 8'd128);
        mstep(1'b0, 1'b1, 1'b1, 12'hABC, 12'hABC, 12'hABC);
        step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 8'd0, 8'd0, 8'd0);
        dstep(12'hABC, 8'hAB);
        dstep(12'd2994, 8'hBB);
        bus.I_en = 1'b1;
        dstep(12'hABC, 8'hAB);
        dstep(12'd4095, 8'hFF);
        dstep(12'd239, 8'h0E);
        step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 8'd0, 8'd0, 8'd0);
        dstep(12'd2994, 8'd128);
        dstep(12'd239, 8'd0);
        flush();

        // Random sync patterns with random pixels
        for (int n = 0; n < 200; n++) begin
            rx = 12'($urandom_range(0, 4095));
            mstep(1'($urandom), 1'($urandom), 1'($urandom), rx, ~rx, rx ^ 12'hF0F);
        end
        flush();

        // Reset mid-line while in bypass with pixels in flight
        bus.I_en = 1'b0;
        step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 8'd0, 8'd0, 8'd0);
        repeat (10) dstep(12'd2994, 8'hBB);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_de", int'(bus.O_de), 0);
        check_eq("arst_r", int'(bus.O_r), 0);
        check_eq("arst_g", int'(bus.O_g), 0);
        check_eq("arst_b", int'(bus.O_b), 0);
        clear_pend();
        bus.I_de = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) dstep(12'd2994, 8'd128);
        dstep(12'd395, 8'd0);
        dstep(12'd4095, 8'd255);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
